// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared ECC definitions: validator FSM states and latency constants
// Ports: none (package).
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        MUL_YY  = 3'd2,
        MUL_XX  = 3'd3,
        MUL_XXX = 3'd4,
        MUL_AX  = 3'd5,
        SUM     = 3'd6,
        DONE    = 3'd7
    } pv_state_t;

    // Number of serial products in a full on-curve check.
    localparam int PV_NUM_PRODUCTS = 4;

    // Start-edge to done latency of the LOAD -> DONE shortcut paths.
    localparam int PV_EARLY_LATENCY = 2;

    // Start-edge to done latency of a full check: LOAD + four (n+1)-cycle
    // products + SUM + DONE.
    function automatic int pv_full_latency(input int width);
        return PV_NUM_PRODUCTS * (width + 1) + 3;
    endfunction

endpackage

// File: rtl/mod_mult.sv
// rtl/mod_mult.sv - serial interleaved modular multiplier, R = A*B mod p
// Parameter n: operand width.
// Ports: clk, reset (async active-low), start (load operands when idle),
//        A, B, p (operands, A < p), busy (running), done (R valid this cycle),
//        R (product, valid while done is high).
module mod_mult #(
    parameter int n = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] p,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] R
);

    localparam int CW = $clog2(n + 1);

    logic [n-1:0]  a_r, b_r, p_r, acc;
    logic [CW-1:0] cnt;
    logic          running;
    logic [n:0]    dbl, dbl_red, sum, sum_red;

    // One MSB-first step: acc = 2*acc (+ a if the current bit of b is set),
    // kept below p after each addition so n+1 bits always suffice.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, p_r}) ? dbl - {1'b0, p_r} : dbl;
        sum     = dbl_red + {1'b0, a_r};
        sum_red = (sum >= {1'b0, p_r}) ? sum - {1'b0, p_r} : sum;
        R       = b_r[n-1] ? sum_red[n-1:0] : dbl_red[n-1:0];
    end

    assign busy = running;
    // The final step lands on the next edge, so R is the finished product now.
    assign done = running && (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r     <= '0;
            b_r     <= '0;
            p_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            a_r     <= A;
            b_r     <= B;
            p_r     <= p;
            acc     <= '0;
            cnt     <= CW'(n);
            running <= 1'b1;
        end else if (running) begin
            acc <= R;
            b_r <= {b_r[n-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/point_validator.sv
// rtl/point_validator.sv - checks whether (x,y) lies on y^2 = x^3 + a*x + b mod p
// Parameter n: field-element width. Optional macro POINT_VALIDATOR_RANGE_CHECK_EN
// rejects unreduced x or y early.
// Ports: clk, reset (async active-low), start, p/a/b (curve), x/y (point),
//        busy, done (one-cycle verdict strobe), on_curve, is_infinity (held verdicts).
module point_validator
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         on_curve,
    output logic         is_infinity
);

    pv_state_t    state, state_next;
    logic [n-1:0] p_r, a_r, b_r, x_r, y_r;
    logic [n-1:0] yy_r, xx_r, xxx_r, ax_r;
    logic [n-1:0] mul_a, mul_b, m_r, rhs;
    logic         m_start, m_busy, m_done, is_mul;
    logic         verdict_set, verdict_on, verdict_inf;

    // Modular add of two reduced operands with an n+1-bit intermediate.
    function automatic logic [n-1:0] mod_add(input logic [n-1:0] u, input logic [n-1:0] v,
                                             input logic [n-1:0] m);
        logic [n:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[n-1:0];
    endfunction

    assign rhs     = mod_add(mod_add(xxx_r, ax_r, p_r), b_r, p_r);
    assign is_mul  = state inside {MUL_YY, MUL_XX, MUL_XXX, MUL_AX};
    // The first cycle of each product state is the multiplier load cycle.
    assign m_start = is_mul && !m_busy;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    mod_mult #(.n(n)) u_mod_mult (
        .clk   (clk),
        .reset (reset),
        .start (m_start),
        .A     (mul_a),
        .B     (mul_b),
        .p     (p_r),
        .busy  (m_busy),
        .done  (m_done),
        .R     (m_r)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        mul_a       = '0;
        mul_b       = '0;
        verdict_set = 1'b0;
        verdict_on  = 1'b0;
        verdict_inf = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (x_r == '0 && y_r == '0) begin
                    state_next  = DONE;
                    verdict_set = 1'b1;
                    verdict_on  = 1'b1;
                    verdict_inf = 1'b1;
                end
`ifdef POINT_VALIDATOR_RANGE_CHECK_EN
                else if (x_r >= p_r || y_r >= p_r) begin
                    state_next  = DONE;
                    verdict_set = 1'b1;
                end
`endif
                else begin
                    state_next = MUL_YY;
                end
            end
            MUL_YY: begin
                mul_a = y_r;
                mul_b = y_r;
                if (m_done) state_next = MUL_XX;
            end
            MUL_XX: begin
                mul_a = x_r;
                mul_b = x_r;
                if (m_done) state_next = MUL_XXX;
            end
            MUL_XXX: begin
                mul_a = xx_r;
                mul_b = x_r;
                if (m_done) state_next = MUL_AX;
            end
            MUL_AX: begin
                mul_a = a_r;
                mul_b = x_r;
                if (m_done) state_next = SUM;
            end
            SUM: begin
                state_next  = DONE;
                verdict_set = 1'b1;
                verdict_on  = (yy_r == rhs);
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            x_r         <= '0;
            y_r         <= '0;
            yy_r        <= '0;
            xx_r        <= '0;
            xxx_r       <= '0;
            ax_r        <= '0;
            on_curve    <= 1'b0;
            is_infinity <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                p_r         <= p;
                a_r         <= a;
                b_r         <= b;
                x_r         <= x;
                y_r         <= y;
                on_curve    <= 1'b0;
                is_infinity <= 1'b0;
            end
            if (m_done) begin
                case (state)
                    MUL_YY:  yy_r  <= m_r;
                    MUL_XX:  xx_r  <= m_r;
                    MUL_XXX: xxx_r <= m_r;
                    MUL_AX:  ax_r  <= m_r;
                    default: ;
                endcase
            end
            if (verdict_set) begin
                on_curve    <= verdict_on;
                is_infinity <= verdict_inf;
            end
        end
    end

endmodule

// File: doc/point_validator.md
POINT_VALIDATOR -- requirements
Module: point_validator

Interface
REQ-001 SHALL have parameter n, default 231, giving the field-element width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to check one point; sampled only in IDLE.
REQ-005 SHALL have ports p, a, b, input, n bits each: the prime modulus and the curve coefficients of y^2 = x^3 + a*x + b.
REQ-006 SHALL have ports x, y, input, n bits each: the point under test, such as a point_doubling result.
REQ-007 SHALL have port busy, output, 1 bit: high from the accepted start until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking valid verdict outputs.
REQ-009 SHALL have port on_curve, output, 1 bit: verdict, held until the next accepted start.
REQ-010 SHALL have port is_infinity, output, 1 bit: the input was the point at infinity, held like on_curve.

Function
REQ-011 SHALL latch p, a, b, x and y on the edge where start=1 and the state is IDLE; later input changes SHALL NOT affect the run.
REQ-012 SHALL ignore start while busy=1, with no queueing and no restart.
REQ-013 SHALL use these FSM states: IDLE, LOAD, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, SUM, DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-014 SHALL step through the computation in this order: y*y, x*x, (x*x)*x, a*x; each product SHALL be reduced mod p and the four SHALL be computed serially on one shared multiplier.
REQ-015 SHALL take exactly n+1 cycles per product: 1 cycle to load the multiplier, then n cycles of interleaved shift-add reduction, MSB first.
REQ-016 SHALL compute rhs = (x^3 + a*x + b) mod p in SUM using modular adds, subtracting p whenever a sum is >= p; intermediates SHALL be n+1 bits wide.
REQ-017 SHALL set on_curve = (y^2 mod p == rhs).
REQ-018 SHALL pulse done exactly 4(n+1)+3 cycles after the start-accepting edge for a full computation.
REQ-019 SHALL treat (x,y) == (0,0) as the point at infinity: go from LOAD straight to DONE, with is_infinity=1, on_curve=1, and done 2 cycles after start.
REQ-020 SHALL operate on operands a and b as given; the caller guarantees a,b < p, p odd, and p >= 3.
REQ-021 SHALL, when start is asserted in the same cycle that done pulses, ignore that start; a new start is accepted only from the following cycle, in IDLE.

Reset
REQ-022 SHALL, while reset=0, force the state to IDLE and busy, done, on_curve and is_infinity to 0, and clear all datapath registers.
REQ-023 SHALL, when reset asserts mid-computation, abort immediately with no done pulse; after release the block SHALL accept a new start.

Configuration
REQ-024 SHALL support the macro POINT_VALIDATOR_RANGE_CHECK_EN.
REQ-025 SHALL, when POINT_VALIDATOR_RANGE_CHECK_EN is defined, reject x >= p or y >= p in LOAD: go straight to DONE with on_curve=0, is_infinity=0, and done 2 cycles after start. The infinity check SHALL take priority over this check.
REQ-026 SHALL, when POINT_VALIDATOR_RANGE_CHECK_EN is undefined, omit the range check and leave behaviour for unreduced x or y undefined; all other timing SHALL be unchanged.

Structure
REQ-027 SHALL place the FSM state enumeration and the latency constants in a shared package, ecc_pkg, for reuse by other ECC blocks.
REQ-028 SHALL implement the multiplier as one sub-module, mod_mult #(n), with start/done handshake, operands A, B, p, and output R = A*B mod p.
REQ-029 SHALL contain no combinational `*` or `%` operators on n-bit operands; all products SHALL go through mod_mult.

Verification (n=8, p=23, a=1, b=1)
REQ-030 SHALL verify an on-curve point: x=3, y=10 -> done at cycle 39 (4*9+3), on_curve=1, is_infinity=0.
REQ-031 SHALL verify an off-curve point: x=3, y=11 (121 mod 23 = 6, not 8) -> done at cycle 39, on_curve=0.
REQ-032 SHALL verify infinity: x=0, y=0 -> done at cycle 2, is_infinity=1, on_curve=1.
REQ-033 SHALL verify the range check with the macro defined: x=25, y=1 -> done at cycle 2, on_curve=0. With the macro undefined, no early done.
REQ-034 SHALL verify start while busy: second start at cycle 10 with x=0, y=0 -> ignored; the single done at cycle 39 reports on_curve=1 for (3,10).
REQ-035 SHALL verify reset mid-run: reset=0 at cycle 20 -> all outputs 0 and no done; a restart with (3,10) -> done 39 cycles after the new start.
